// File: rtl/stage_ex_md_if.sv
// ---------------------------------------------------------------------------
// stage_ex_md_if
//   Bundles the ID/EX -> EX signals and the EX stage results for stage_ex_md.
//   Clock and reset stay outside as plain ports of the stage.
//
//   Ports (all logic):
//     i_isValid, i_flush                    instruction valid / kill
//     i_instIMM, i_dataRS1, i_dataRS2, i_pc operands (DATA_WIDTH)
//     i_operandASel, i_operandBSel          operand muxes (2)
//     i_resultSel                           0 ALU, 1 CSR, 2 MD, 3 zero (2)
//     i_aluControl                          ALU op (4)
//     i_mdOp                                RV M-extension funct3 (3)
//     i_csrData                             CSR read data (DATA_WIDTH)
//     o_hazard, o_dataR, o_dataB, o_mdBusy  stage outputs
//     o_mdState                             MD FSM state (debug)
//
//   Modports: master = pipeline side driving the stage, slave = the stage.
// ---------------------------------------------------------------------------
interface stage_ex_md_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_isValid;
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] i_instIMM;
  logic [DATA_WIDTH-1:0] i_dataRS1;
  logic [DATA_WIDTH-1:0] i_dataRS2;
  logic [DATA_WIDTH-1:0] i_pc;
  logic [1:0]            i_operandASel;
  logic [1:0]            i_operandBSel;
  logic [1:0]            i_resultSel;
  logic [3:0]            i_aluControl;
  logic [2:0]            i_mdOp;
  logic [DATA_WIDTH-1:0] i_csrData;
  logic                  o_hazard;
  logic [DATA_WIDTH-1:0] o_dataR;
  logic [DATA_WIDTH-1:0] o_dataB;
  logic                  o_mdBusy;
  logic [1:0]            o_mdState;

  modport master (
    output i_isValid, i_flush, i_instIMM, i_dataRS1, i_dataRS2, i_pc,
           i_operandASel, i_operandBSel, i_resultSel, i_aluControl,
           i_mdOp, i_csrData,
    input  o_hazard, o_dataR, o_dataB, o_mdBusy, o_mdState
  );

  modport slave (
    input  i_isValid, i_flush, i_instIMM, i_dataRS1, i_dataRS2, i_pc,
           i_operandASel, i_operandBSel, i_resultSel, i_aluControl,
           i_mdOp, i_csrData,
    output o_hazard, o_dataR, o_dataB, o_mdBusy, o_mdState
  );
endinterface

// File: rtl/stage_ex_md.sv
// ---------------------------------------------------------------------------
// stage_ex_md
//   Execute stage: single-cycle ALU / CSR / zero result path plus an
//   iterative RV32M/RV64M multiply/divide unit (shift-add multiplier retiring
//   MUL_BITS_PER_CYCLE bits per cycle, restoring 1-bit/cycle divider).
//
//   Ports:
//     i_clock  rising-edge clock
//     i_reset  asynchronous, active-low reset
//     bus      stage_ex_md_if.slave (operands, selects, results, debug)
//
//   Stall handshake: o_hazard is the only flow control. While it is high the
//   upstream pipeline holds every EX input stable. An instruction retires at
//   the end of the first cycle in which i_isValid is high and o_hazard is low.
//   For an M-op that cycle is DONE, where o_dataR shows the registered result.
// ---------------------------------------------------------------------------
module stage_ex_md #(
  parameter int DATA_WIDTH         = 32,
  parameter int MUL_BITS_PER_CYCLE = 4,
  parameter bit ENABLE_MD          = 1'b1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  stage_ex_md_if.slave bus
);

  localparam int W   = DATA_WIDTH;
  localparam int K   = MUL_BITS_PER_CYCLE;
  localparam int CW  = $clog2(DATA_WIDTH) + 1;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] MUL_N   = CW'(DATA_WIDTH / MUL_BITS_PER_CYCLE);
  localparam logic [CW-1:0] DIV_N   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [W-1:0]  MIN_VAL = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // ---------------- single-cycle ALU path ----------------
  logic [W-1:0]   op_a, op_b, alu_res;
  logic [SHW-1:0] shamt;

  always_comb begin
    case (bus.i_operandASel)
      2'd0:    op_a = bus.i_dataRS1;
      2'd1:    op_a = bus.i_instIMM;
      2'd2:    op_a = '0;
      default: op_a = bus.i_pc;
    endcase
    case (bus.i_operandBSel)
      2'd0:    op_b = bus.i_dataRS2;
      2'd1:    op_b = bus.i_instIMM;
      2'd2:    op_b = {{(W-3){1'b0}}, 3'd4};
      default: op_b = '0;
    endcase
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    case (bus.i_aluControl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // ---------------- MD unit state ----------------
  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;     // running product
  logic [2*W-1:0] mcand_q, mcand_d;   // multiplicand, shifted left K per cycle
  logic [W-1:0]   mplier_q, mplier_d; // multiplier, shifted right K per cycle
  logic [W-1:0]   rem_q, rem_d;       // partial remainder
  logic [W-1:0]   quo_q, quo_d;       // dividend shifting out / quotient in
  logic [W-1:0]   dvsr_q, dvsr_d;     // divisor magnitude
  logic           neg_q, neg_d;       // product / quotient sign
  logic           negr_q, negr_d;     // remainder sign (dividend sign)
  logic [1:0]     op_q, op_d;         // low funct3 bits pick half / Q vs R
  logic [W-1:0]   res_q, res_d;       // registered MD result

  // Operand preparation for the start cycle, straight from RS1/RS2.
  logic         a_signed, b_signed, a_neg, b_neg, is_div, md_start;
  logic [W-1:0] a_mag, b_mag, fast_res;
  logic         div_zero, div_ovf;

  always_comb begin
    is_div   = bus.i_mdOp[2];
    // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed.
    a_signed = is_div ? ~bus.i_mdOp[0] : (bus.i_mdOp[1:0] != 2'b11);
    b_signed = is_div ? ~bus.i_mdOp[0] : ~bus.i_mdOp[1];
    a_neg    = a_signed & bus.i_dataRS1[W-1];
    b_neg    = b_signed & bus.i_dataRS2[W-1];
    a_mag    = a_neg ? -bus.i_dataRS1 : bus.i_dataRS1;
    b_mag    = b_neg ? -bus.i_dataRS2 : bus.i_dataRS2;
    div_zero = (bus.i_dataRS2 == '0);
    div_ovf  = ~bus.i_mdOp[0] & (bus.i_dataRS1 == MIN_VAL) & (bus.i_dataRS2 == '1);
    // Both special cases resolve without iterating; op[1] selects remainder.
    if (div_zero)
      fast_res = bus.i_mdOp[1] ? bus.i_dataRS1 : '1;
    else
      fast_res = bus.i_mdOp[1] ? '0 : MIN_VAL;
  end

  assign md_start = ENABLE_MD & bus.i_isValid & ~bus.i_flush &
                    (bus.i_resultSel == 2'd2) & (state_q == ST_IDLE);

  // One multiply step: add K shifted copies of the multiplicand.
  logic [2*W-1:0] mul_add, prod_nx, prod_fin;
  logic [W-1:0]   mul_res;

  always_comb begin
    mul_add = '0;
    for (int j = 0; j < K; j++) begin
      if (mplier_q[j]) mul_add = mul_add + (mcand_q << j);
    end
    prod_nx  = prod_q + mul_add;
    prod_fin = neg_q ? -prod_nx : prod_nx;
    mul_res  = (op_q == 2'b00) ? prod_fin[W-1:0] : prod_fin[2*W-1:W];
  end

  // One restoring divide step.
  logic [W:0]   div_trial;
  logic         div_ge;
  logic [W-1:0] rem_nx, quo_nx, q_fin, r_fin, div_res;

  always_comb begin
    div_trial = {rem_q, quo_q[W-1]};
    div_ge    = (div_trial >= {1'b0, dvsr_q});
    rem_nx    = div_ge ? (div_trial[W-1:0] - dvsr_q) : div_trial[W-1:0];
    quo_nx    = {quo_q[W-2:0], div_ge};
    q_fin     = neg_q  ? -quo_nx : quo_nx;
    r_fin     = negr_q ? -rem_nx : rem_nx;
    div_res   = op_q[1] ? r_fin : q_fin;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    op_d     = op_q;
    res_d    = res_q;

    if (bus.i_flush) begin
      // Kill: drop whatever is in flight, result register untouched.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_start) begin
            op_d     = bus.i_mdOp[1:0];
            neg_d    = a_neg ^ b_neg;
            negr_d   = a_neg;
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = {{W{1'b0}}, a_mag};
            mplier_d = b_mag;
            rem_d    = '0;
            quo_d    = a_mag;
            dvsr_d   = b_mag;
            if (is_div && (div_zero || div_ovf)) begin
              res_d   = fast_res;
              state_d = ST_DONE;
            end else begin
              state_d = is_div ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL: begin
          prod_d   = prod_nx;
          mcand_d  = mcand_q << K;
          mplier_d = mplier_q >> K;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_d == MUL_N) begin
            res_d   = mul_res;
            state_d = ST_DONE;
          end
        end
        ST_DIV: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == DIV_N) begin
            res_d   = div_res;
            state_d = ST_DONE;
          end
        end
        default: begin
          // DONE: pipeline advances this cycle; never chains a new op.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      op_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      op_q     <= op_d;
      res_q    <= res_d;
    end
  end

  // ---------------- outputs ----------------
  logic [W-1:0] md_data;
  assign md_data = ENABLE_MD ? res_q : '0;

  always_comb begin
    case (bus.i_resultSel)
      2'd0:    bus.o_dataR = alu_res;
      2'd1:    bus.o_dataR = bus.i_csrData;
      2'd2:    bus.o_dataR = md_data;
      default: bus.o_dataR = '0;
    endcase
  end

  // Stall in the start cycle and every iterate cycle; flush and reset win.
  assign bus.o_hazard  = i_reset & ~bus.i_flush &
                         (md_start | (state_q == ST_MUL) | (state_q == ST_DIV));
  assign bus.o_dataB   = bus.i_dataRS2;
  assign bus.o_mdBusy  = (state_q != ST_IDLE);
  assign bus.o_mdState = state_q;

endmodule

// File: tb/tb_stage_ex_md.sv
// ---------------------------------------------------------------------------
// tb_stage_ex_md
//   Directed bench for stage_ex_md (32-bit, 4 multiplier bits per cycle).
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_stage_ex_md;
  localparam int DW = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage_ex_md_if #(.DATA_WIDTH(DW)) bus ();

  stage_ex_md #(
    .DATA_WIDTH        (DW),
    .MUL_BITS_PER_CYCLE(4),
    .ENABLE_MD         (1'b1)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.i_isValid     = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_instIMM     = '0;
    bus.i_dataRS1     = '0;
    bus.i_dataRS2     = '0;
    bus.i_pc          = '0;
    bus.i_operandASel = 2'd0;
    bus.i_operandBSel = 2'd0;
    bus.i_resultSel   = 2'd0;
    bus.i_aluControl  = ALU_ADD;
    bus.i_mdOp        = MD_MUL;
    bus.i_csrData     = '0;
  endtask

  // Called just after a rising edge; checks the single-cycle result.
  task automatic alu_op(input string tag, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [1:0] rsel, input logic [3:0] ctrl,
                        input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                        input logic [DW-1:0] imm, input logic [DW-1:0] pc,
                        input logic [DW-1:0] csr, input logic [DW-1:0] exp);
    bus.i_isValid     = 1'b1;
    bus.i_flush       = 1'b0;
    bus.i_operandASel = asel;
    bus.i_operandBSel = bsel;
    bus.i_resultSel   = rsel;
    bus.i_aluControl  = ctrl;
    bus.i_dataRS1     = rs1;
    bus.i_dataRS2     = rs2;
    bus.i_instIMM     = imm;
    bus.i_pc          = pc;
    bus.i_csrData     = csr;
    @(negedge clk);
    check(tag, bus.o_dataR, exp);
    check({tag, "_hz"}, {31'd0, bus.o_hazard}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Issues one M-op, counts hazard cycles (bounded), checks the DONE result.
  // Operands are scrambled after the start cycle: they must be ignored.
  task automatic md_op(input string tag, input logic [2:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int exp_hz, input logic [DW-1:0] exp_res);
    int n;
    logic [DW-1:0] exp;
    exp_q.push_back(exp_res);
    bus.i_isValid   = 1'b1;
    bus.i_flush     = 1'b0;
    bus.i_resultSel = 2'd2;
    bus.i_mdOp      = op;
    bus.i_dataRS1   = a;
    bus.i_dataRS2   = b;
    n = 0;
    @(negedge clk);
    while (bus.o_hazard === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
      bus.i_dataRS1 = $urandom;
      bus.i_dataRS2 = $urandom;
      @(negedge clk);
    end
    check({tag, "_hz"}, n, exp_hz);
    exp = exp_q.pop_front();
    check({tag, "_res"}, bus.o_dataR, exp);
    check({tag, "_busy"}, {31'd0, bus.o_mdBusy}, 32'd1);
    @(posedge clk); #1;
    bus.i_isValid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    bus.i_resultSel = 2'd2;

    // Reset state.
    @(negedge clk);
    check("rst_hz",    {31'd0, bus.o_hazard}, 32'd0);
    check("rst_busy",  {31'd0, bus.o_mdBusy}, 32'd0);
    check("rst_state", {30'd0, bus.o_mdState}, 32'd0);
    check("rst_res",   bus.o_dataR, 32'd0);
    // A would-be start while reset is low must not raise the stall.
    bus.i_isValid = 1'b1;
    #1;
    check("rst_start_hz", {31'd0, bus.o_hazard}, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle paths.
    alu_op("add",  2'd0, 2'd0, 2'd0, ALU_ADD,  32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd5);
    alu_op("sub",  2'd0, 2'd0, 2'd0, ALU_SUB,  32'd10, 32'd3, 32'd0, 32'd0, 32'd0, 32'd7);
    alu_op("pc4",  2'd3, 2'd2, 2'd0, ALU_ADD,  32'd0, 32'd0, 32'd0, 32'h1000, 32'd0, 32'h1004);
    alu_op("lui",  2'd2, 2'd1, 2'd0, ALU_ADD,  32'd0, 32'd0, 32'hABCD0000, 32'd0, 32'd0, 32'hABCD0000);
    alu_op("xor",  2'd0, 2'd0, 2'd0, ALU_XOR,  32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'd0, 32'hFF00);
    alu_op("sra",  2'd0, 2'd1, 2'd0, ALU_SRA,  32'h80000000, 32'd0, 32'd4, 32'd0, 32'd0, 32'hF8000000);
    alu_op("slt",  2'd0, 2'd0, 2'd0, ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1);
    alu_op("sltu", 2'd0, 2'd0, 2'd0, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    alu_op("csr",  2'd0, 2'd0, 2'd1, ALU_ADD,  32'd1, 32'd2, 32'd0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF);
    alu_op("zero", 2'd0, 2'd0, 2'd3, ALU_ADD,  32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.i_dataRS2 = 32'h12345678;
    #1;
    check("dataB", bus.o_dataB, 32'h12345678);

    // Multiply.
    md_op("mul",    MD_MUL,    32'd7, 32'hFFFFFFFD, 9, 32'hFFFFFFEB);
    md_op("mulhu",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 9, 32'hFFFFFFFE);
    md_op("mulh",   MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 9, 32'h00000000);
    md_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'd2, 9, 32'hFFFFFFFF);

    // Divide, iterative.
    md_op("div",  MD_DIV,  32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
    md_op("rem",  MD_REM,  32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
    md_op("divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd14);
    md_op("remu", MD_REMU, 32'd100, 32'd7, 33, 32'd2);

    // Divide, fast path.
    md_op("divu0",  MD_DIVU, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
    md_op("rem0",   MD_REM,  32'd5, 32'd0, 1, 32'd5);
    md_op("divovf", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    md_op("removf", MD_REM,  32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

    // Not valid, MD selected: no start, last result visible.
    bus.i_resultSel = 2'd2;
    @(negedge clk);
    check("hold_res",  bus.o_dataR, 32'd0);
    check("hold_hz",   {31'd0, bus.o_hazard}, 32'd0);
    check("hold_busy", {31'd0, bus.o_mdBusy}, 32'd0);
    @(posedge clk); #1;

    // Establish a known MD result, then flush a DIV at iterate cycle 4.
    md_op("pre_flush", MD_DIVU, 32'd100, 32'd7, 33, 32'd14);
    bus.i_isValid   = 1'b1;
    bus.i_resultSel = 2'd2;
    bus.i_mdOp      = MD_DIV;
    bus.i_dataRS1   = 32'd1000;
    bus.i_dataRS2   = 32'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("it4_hz", {31'd0, bus.o_hazard}, 32'd1);
    @(posedge clk); #1;
    bus.i_flush = 1'b1;
    #1;
    check("flush_hz",   {31'd0, bus.o_hazard}, 32'd0);
    check("flush_busy", {31'd0, bus.o_mdBusy}, 32'd1);
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    bus.i_isValid = 1'b0;
    #1;
    check("post_flush_busy", {31'd0, bus.o_mdBusy}, 32'd0);
    check("flush_kept_res",  bus.o_dataR, 32'd14);
    alu_op("add_after_flush", 2'd0, 2'd0, 2'd0, ALU_ADD, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd5);

    // Async reset at iterate cycle 3 of a MUL.
    bus.i_isValid   = 1'b1;
    bus.i_resultSel = 2'd2;
    bus.i_mdOp      = MD_MUL;
    bus.i_dataRS1   = 32'd7;
    bus.i_dataRS2   = 32'hFFFFFFFD;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("it3_busy", {31'd0, bus.o_mdBusy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_hz",   {31'd0, bus.o_hazard}, 32'd0);
    check("arst_busy", {31'd0, bus.o_mdBusy}, 32'd0);
    bus.i_isValid = 1'b0;
    #1;
    check("arst_res", bus.o_dataR, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    alu_op("alu_after_rst", 2'd0, 2'd0, 2'd0, ALU_SUB, 32'd10, 32'd3, 32'd0, 32'd0, 32'd0, 32'd7);
    check("post_rst_busy", {31'd0, bus.o_mdBusy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
